// File: rtl/ccff_loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ccff_loader_pkg                                               |
// | Purpose  : Shared types and default sizes for the configuration-chain    |
// |            loader (state encoding, chain length, word and counter width).|
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package ccff_loader_pkg;

  localparam int c_def_bitstream_size = 29696;
  localparam int c_def_word_w         = 32;
  localparam int c_def_cnt_w          = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_TEST   = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

endpackage : ccff_loader_pkg
`default_nettype wire

// File: rtl/ccff_word_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ccff_word_serializer                                          |
// | Purpose  : One-word shift buffer that accepts bitstream words over a     |
// |            valid/ready handshake and presents them MSB-first, one bit    |
// |            per enabled cycle.                                            |
// | Ports    : prog_clk, pReset (sync, active-low)                           |
// |            i_clear       drop any buffered bits                          |
// |            i_en          serializer may accept words and shift           |
// |            i_more        more than one bit still needed by the chain     |
// |            i_word_data / i_word_valid / o_word_ready  word stream        |
// |            o_bit / o_bit_vld  current bit and "bit is consumed" strobe   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ccff_word_serializer
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = c_def_word_w
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              i_clear,
  input  logic              i_en,
  input  logic              i_more,
  input  logic [WORD_W-1:0] i_word_data,
  input  logic              i_word_valid,
  output logic              o_word_ready,
  output logic              o_bit,
  output logic              o_bit_vld
);

  localparam int c_idx_w = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0]  r_buf;
  logic [c_idx_w-1:0] r_idx;
  logic               r_full;
  logic               w_last;
  logic               w_load;

  // Index 0 is the final bit of the buffered word.
  assign w_last       = r_full & (r_idx == '0);
  // Refill in the same cycle the last bit leaves, so valid-held words stream
  // without bubbles; never ask for a word the chain no longer needs.
  assign o_word_ready = i_en & (~r_full | (w_last & i_more));
  assign w_load       = o_word_ready & i_word_valid;
  assign o_bit_vld    = i_en & r_full;
  assign o_bit        = r_buf[r_idx];

  always_ff @(posedge prog_clk) begin
    if (!pReset || i_clear) begin
      r_buf  <= '0;
      r_idx  <= '0;
      r_full <= 1'b0;
    end else if (w_load) begin
      r_buf  <= i_word_data;
      r_idx  <= c_idx_w'(WORD_W - 1);
      r_full <= 1'b1;
    end else if (o_bit_vld) begin
      if (w_last) begin
        r_full <= 1'b0;
      end else begin
        r_idx <= r_idx - c_idx_w'(1);
      end
    end
  end

endmodule : ccff_word_serializer
`default_nettype wire

// File: rtl/ccff_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ccff_loader                                                   |
// | Purpose  : Configuration-chain controller. Serializes 32-bit bitstream   |
// |            words MSB-first onto ccff_head and raises shift_en only for   |
// |            cycles that carry a valid bit. Optional chain-length test     |
// |            injects a single 1 and expects it at ccff_tail after exactly  |
// |            BITSTREAM_SIZE shifts.                                        |
// | Config   : CCFF_LOADER_CHAIN_TEST_EN enables the TEST mode and tail      |
// |            checking; without it mode is ignored and error is 0.          |
// | Ports    : prog_clk, pReset (sync, active-low)                           |
// |            start, mode                 operation request                 |
// |            word_data/word_valid/word_ready  bitstream word stream        |
// |            ccff_head, shift_en         registered chain drive            |
// |            ccff_tail                   chain return                      |
// |            busy, done, error, bit_count  status                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ccff_loader
  import ccff_loader_pkg::*;
#(
  parameter int BITSTREAM_SIZE = c_def_bitstream_size,
  parameter int WORD_W         = c_def_word_w,
  parameter int CNT_W          = c_def_cnt_w
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              mode,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              shift_en,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  bit_count
);

  localparam logic [CNT_W-1:0] c_size    = CNT_W'(BITSTREAM_SIZE);
  localparam logic [CNT_W-1:0] c_size_m1 = CNT_W'(BITSTREAM_SIZE - 1);
  localparam logic [CNT_W-1:0] c_size_p2 = CNT_W'(BITSTREAM_SIZE + 2);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_head;
  logic             w_head_nxt;
  logic             r_shift_en;
  logic             w_shift_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_test_shift;
  logic             w_start_acc;
  logic             w_mode;
  logic             w_bit;
  logic             w_bit_vld;
  logic             w_ser_en;
  logic             w_ser_more;
  logic             w_ser_clear;

  assign w_start_acc = (r_state == ST_IDLE) & start;

  // The serializer only runs while the chain still needs bits; once the
  // count hits the chain length any leftover buffered bits are dropped.
  assign w_ser_en    = (r_state == ST_LOAD) & (r_count < c_size);
  assign w_ser_more  = (r_count < c_size_m1);
  assign w_ser_clear = (r_state != ST_LOAD);

  ccff_word_serializer #(
    .WORD_W (WORD_W)
  ) u_ser (
    .prog_clk     (prog_clk),
    .pReset       (pReset),
    .i_clear      (w_ser_clear),
    .i_en         (w_ser_en),
    .i_more       (w_ser_more),
    .i_word_data  (word_data),
    .i_word_valid (word_valid),
    .o_word_ready (word_ready),
    .o_bit        (w_bit),
    .o_bit_vld    (w_bit_vld)
  );

  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      r_state    <= ST_IDLE;
      r_head     <= 1'b0;
      r_shift_en <= 1'b0;
      r_done     <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_head     <= w_head_nxt;
      r_shift_en <= w_shift_nxt;
      r_done     <= w_done_nxt;
      r_count    <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_head_nxt   = r_head;
    w_shift_nxt  = 1'b0;
    w_done_nxt   = r_done;
    w_count_nxt  = r_count;
    w_test_shift = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_head_nxt = 1'b0;
        if (start) begin
          w_done_nxt  = 1'b0;
          w_count_nxt = '0;
          w_state_nxt = w_mode ? ST_TEST : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (r_count == c_size) begin
          w_head_nxt  = 1'b0;
          w_state_nxt = ST_FINISH;
        end else if (w_bit_vld) begin
          w_head_nxt  = w_bit;
          w_shift_nxt = 1'b1;
          w_count_nxt = r_count + CNT_W'(1);
        end
        // Underflow: head holds and shift_en stays low, chain simply waits.
      end
      ST_TEST: begin
        if (r_count == c_size_p2) begin
          w_head_nxt  = 1'b0;
          w_state_nxt = ST_FINISH;
        end else begin
          w_head_nxt   = (r_count == '0);
          w_shift_nxt  = 1'b1;
          w_count_nxt  = r_count + CNT_W'(1);
          w_test_shift = 1'b1;
        end
      end
      ST_FINISH: begin
        w_head_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef CCFF_LOADER_CHAIN_TEST_EN
  // Tail check pipeline: a shift issued at edge k moves the chain at edge
  // k+1, and the resulting tail level is sampled at edge k+2.
  logic r_chk_vld1;
  logic r_chk_exp1;
  logic r_chk_vld2;
  logic r_chk_exp2;
  logic r_error;

  always_ff @(posedge prog_clk) begin
    if (!pReset || w_start_acc) begin
      r_chk_vld1 <= 1'b0;
      r_chk_exp1 <= 1'b0;
      r_chk_vld2 <= 1'b0;
      r_chk_exp2 <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_chk_vld1 <= w_test_shift;
      r_chk_exp1 <= (w_count_nxt == c_size);
      r_chk_vld2 <= r_chk_vld1;
      r_chk_exp2 <= r_chk_exp1;
      if (r_chk_vld2 && (ccff_tail != r_chk_exp2)) begin
        r_error <= 1'b1;
      end
    end
  end

  assign error  = r_error;
  assign w_mode = mode;
`else
  logic w_unused;
  assign w_unused = ^{ccff_tail, mode, w_test_shift};
  assign error    = 1'b0;
  assign w_mode   = 1'b0;
`endif

  assign ccff_head = r_head;
  assign shift_en  = r_shift_en;
  assign done      = r_done;
  assign bit_count = r_count;
  assign busy      = (r_state != ST_IDLE);

endmodule : ccff_loader
`default_nettype wire
